// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: parametrised Fibonacci LFSR random source with random tick and wrap pulses.
// Define LFSR_LOCKUP_RECOVER_EN to reload SEED when stepping from the all-zero state.
module lfsr_rand_gen #(
    parameter int BW_LFSR = 8,
    parameter logic [BW_LFSR-1:0] SEED = BW_LFSR'(1),
    parameter logic [31:0] TAPS = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_load,
    input  logic [BW_LFSR-1:0] i_seed,
    input  logic [BW_LFSR-1:0] i_thresh,
    output logic [BW_LFSR-1:0] o_lfsr,
    output logic               o_tick,
    output logic               o_wrap,
    output logic               o_lockup
);
    function automatic logic [31:0] max_taps(input int w);
        case (w)
            3:  max_taps = 32'h00000006;
            4:  max_taps = 32'h0000000C;
            5:  max_taps = 32'h00000014;
            6:  max_taps = 32'h00000030;
            7:  max_taps = 32'h00000060;
            8:  max_taps = 32'h000000B8;
            9:  max_taps = 32'h00000110;
            10: max_taps = 32'h00000240;
            11: max_taps = 32'h00000500;
            12: max_taps = 32'h00000829;
            13: max_taps = 32'h0000100D;
            14: max_taps = 32'h00002015;
            15: max_taps = 32'h00006000;
            16: max_taps = 32'h0000D008;
            17: max_taps = 32'h00012000;
            18: max_taps = 32'h00020400;
            19: max_taps = 32'h00040023;
            20: max_taps = 32'h00090000;
            21: max_taps = 32'h00140000;
            22: max_taps = 32'h00300000;
            23: max_taps = 32'h00420000;
            24: max_taps = 32'h00E10000;
            25: max_taps = 32'h01200000;
            26: max_taps = 32'h02000023;
            27: max_taps = 32'h04000013;
            28: max_taps = 32'h09000000;
            29: max_taps = 32'h14000000;
            30: max_taps = 32'h20000029;
            31: max_taps = 32'h48000000;
            32: max_taps = 32'h80200003;
            default: max_taps = 32'h0;
        endcase
    endfunction

    localparam logic [31:0] TAB = max_taps(BW_LFSR);
    localparam logic [BW_LFSR-1:0] MASK = BW_LFSR'((TAPS != '0) ? TAPS : TAB);

    logic [BW_LFSR-1:0] start;
    logic [BW_LFSR-1:0] nxt;
    logic               recover;

    // shift left and feed the parity of the tapped stages into bit 0
    always_comb nxt = {o_lfsr[BW_LFSR-2:0], ^(o_lfsr & MASK)};

`ifdef LFSR_LOCKUP_RECOVER_EN
    assign recover = (o_lfsr == '0);
`else
    assign recover = 1'b0;
`endif

    // register state, origin and per-step pulses; reset > load > step > hold
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_lfsr   <= SEED;
            start    <= SEED;
            o_tick   <= 1'b0;
            o_wrap   <= 1'b0;
            o_lockup <= 1'b0;
        end else if (i_load) begin
            o_lfsr   <= i_seed;
            start    <= i_seed;
            o_tick   <= 1'b0;
            o_wrap   <= 1'b0;
            o_lockup <= (i_seed == '0);
        end else if (i_en && recover) begin
            o_lfsr   <= SEED;
            start    <= SEED;
            o_tick   <= 1'b0;
            o_wrap   <= 1'b0;
            o_lockup <= 1'b0;
        end else if (i_en) begin
            o_lfsr   <= nxt;
            o_tick   <= (nxt < i_thresh);
            o_wrap   <= (nxt == start);
            o_lockup <= (nxt == '0);
        end else begin
            o_tick   <= 1'b0;
            o_wrap   <= 1'b0;
        end
    end

    a_seed_nonzero: assert property (@(posedge i_clk) SEED != '0);
    a_width_legal:  assert property (@(posedge i_clk) BW_LFSR >= 3 && BW_LFSR <= 32);
endmodule

// File: tb/tb_lfsr_rand_gen.sv
// tb_lfsr_rand_gen: directed test-plan checks plus randomized run against a behavioural model.
module tb_lfsr_rand_gen;
    logic       clk = 1'b0;
    logic       rst, en, load;
    logic [7:0] seed, thresh;
    logic [7:0] lfsr;
    logic       tick, wrap, lockup;

    always #5 clk = ~clk;

    lfsr_rand_gen #(.BW_LFSR(8), .SEED(8'h01), .TAPS(32'h0)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_load(load), .i_seed(seed),
        .i_thresh(thresh), .o_lfsr(lfsr), .o_tick(tick), .o_wrap(wrap), .o_lockup(lockup)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_lfsr, m_start, m_tick, m_wrap;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // taps 8,6,5,4 of the 8-bit maximal-length polynomial
    function automatic int lfsr_next(input int v);
        return ((v * 2) % 256) + ($countones(v & 'hB8) % 2);
    endfunction

    task automatic model_edge();
        int n;
        if (rst) begin
            m_lfsr = 1; m_start = 1; m_tick = 0; m_wrap = 0;
        end else if (load) begin
            m_lfsr = seed; m_start = seed; m_tick = 0; m_wrap = 0;
        end else if (en) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (m_lfsr == 0) begin
                m_lfsr = 1; m_start = 1; m_tick = 0; m_wrap = 0;
            end else begin
`else
            begin
`endif
                n = lfsr_next(m_lfsr);
                m_tick = (n < int'(thresh)) ? 1 : 0;
                m_wrap = (n == m_start) ? 1 : 0;
                m_lfsr = n;
            end
        end else begin
            m_tick = 0; m_wrap = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("lfsr", int'(lfsr), m_lfsr);
        check("tick", int'(tick), m_tick);
        check("wrap", int'(wrap), m_wrap);
        check("lockup", int'(lockup), (m_lfsr == 0) ? 1 : 0);
    endtask

    task automatic period(input logic [7:0] th, output int ticks, output int wraps,
                          output int wrap_at, output int wrap_val, output int distinct);
        int seen[256];
        thresh = th;
        ticks = 0; wraps = 0; wrap_at = -1; wrap_val = -1; distinct = 0;
        for (int k = 0; k < 256; k++) seen[k] = 0;
        for (int i = 1; i <= 255; i++) begin
            step();
            if (tick) ticks++;
            if (wrap) begin wraps++; wrap_at = i; wrap_val = int'(lfsr); end
            if (seen[lfsr] == 0) distinct++;
            seen[lfsr]++;
        end
    endtask

    initial begin
        int seq[7];
        int ticks, wraps, wrap_at, wrap_val, distinct;
        seq = '{'h01, 'h02, 'h04, 'h08, 'h11, 'h23, 'h47};
        rst = 1; en = 0; load = 0; seed = 0; thresh = 0;
        repeat (2) step();
        check("rst_lfsr", int'(lfsr), 1);
        check("rst_tick", int'(tick), 0);
        check("rst_wrap", int'(wrap), 0);
        check("rst_lockup", int'(lockup), 0);
        rst = 0; en = 1;
        check("seq0", int'(lfsr), seq[0]);
        for (int i = 1; i < 7; i++) begin
            step();
            check("seq", int'(lfsr), seq[i]);
        end
        rst = 1; step(); rst = 0;
        period(8'h80, ticks, wraps, wrap_at, wrap_val, distinct);
        check("per_wraps", wraps, 1);
        check("per_wrap_at", wrap_at, 255);
        check("per_wrap_val", wrap_val, 1);
        check("per_distinct", distinct, 255);
        check("ticks_80", ticks, 127);
        period(8'hFF, ticks, wraps, wrap_at, wrap_val, distinct);
        check("ticks_ff", ticks, 254);
        period(8'h00, ticks, wraps, wrap_at, wrap_val, distinct);
        check("ticks_00", ticks, 0);

        rst = 1; step(); rst = 0;
        repeat (40) step();
        load = 1; seed = 8'hA5; thresh = 8'hFF;
        step();
        check("load_val", int'(lfsr), 'hA5);
        check("load_tick", int'(tick), 0);
        load = 0;
        period(8'hFF, ticks, wraps, wrap_at, wrap_val, distinct);
        check("load_wraps", wraps, 1);
        check("load_wrap_at", wrap_at, 255);
        check("load_wrap_val", wrap_val, 'hA5);

        en = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_lfsr", int'(lfsr), 'hA5);
            check("hold_tick", int'(tick), 0);
        end

        en = 1; load = 1; seed = 8'h00;
        step();
        check("lock_lfsr", int'(lfsr), 0);
        check("lock_flag", int'(lockup), 1);
        load = 0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        step();
        check("recover_lfsr", int'(lfsr), 1);
        check("recover_flag", int'(lockup), 0);
`else
        for (int i = 0; i < 10; i++) begin
            step();
            check("stuck_lfsr", int'(lfsr), 0);
            check("stuck_flag", int'(lockup), 1);
        end
`endif

        rst = 1; step(); rst = 0; en = 1;
        repeat (100) step();
        rst = 1; load = 1; seed = 8'($urandom);
        step();
        check("mid_rst_lfsr", int'(lfsr), 1);
        check("mid_rst_tick", int'(tick), 0);
        check("mid_rst_wrap", int'(wrap), 0);
        rst = 0; load = 0;
        step();
        check("mid_rst_next", int'(lfsr), 2);

        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(99) == 0);
            load   = ($urandom_range(19) == 0);
            en     = ($urandom_range(3) != 0);
            seed   = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
            thresh = 8'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
